// File: rtl/frame_deframer.sv
// Receive-side deframer: strips header/footer, forwards payload, checks footer seq/len.
// Optional macro FRAME_TIMEOUT_EN adds an idle-cycle abort inside a frame.
module frame_deframer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_LEN    = 381,
  parameter logic [DATA_WIDTH-1:0] HEADER_WORD = DATA_WIDTH'(32'hFFFF_FFFF)
`ifdef FRAME_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  validIn,
  input  logic                  lastIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
  output logic                  lastOut,
  output logic                  pktDone,
  output logic [15:0]           seqOut,
  output logic [15:0]           lenOut,
  output logic                  seqErr,
  output logic                  lenErr,
  output logic                  ovfErr,
  output logic                  hdrErr,
  output logic                  toErr
);

  localparam int unsigned CNT_W = 16;
`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

  typedef enum logic {ST_IDLE, ST_PAYLOAD} state_t;

  state_t                r_state,   w_state_nxt;
  logic [DATA_WIDTH-1:0] r_hold,    w_hold_nxt;
  logic                  r_full,    w_full_nxt;
  logic [CNT_W-1:0]      r_count,   w_count_nxt;
  logic                  r_ovf,     w_ovf_nxt;
  logic [15:0]           r_exp_seq, w_exp_seq_nxt;

  logic [DATA_WIDTH-1:0] r_dout,    w_dout_nxt;
  logic                  r_vout,    w_vout_nxt;
  logic                  r_lout,    w_lout_nxt;
  logic                  r_done,    w_done_nxt;
  logic [15:0]           r_seq_out, w_seq_out_nxt;
  logic [15:0]           r_len_out, w_len_out_nxt;
  logic                  r_seq_err, w_seq_err_nxt;
  logic                  r_len_err, w_len_err_nxt;
  logic                  r_ovf_err, w_ovf_err_nxt;
  logic                  r_hdr_err, w_hdr_err_nxt;
`ifdef FRAME_TIMEOUT_EN
  logic [IDLE_W-1:0]     r_idle,    w_idle_nxt;
  logic                  r_to_err,  w_to_err_nxt;
`endif

  // State and output registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_hold    <= '0;
      r_full    <= 1'b0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_exp_seq <= 16'd1;
      r_dout    <= '0;
      r_vout    <= 1'b0;
      r_lout    <= 1'b0;
      r_done    <= 1'b0;
      r_seq_out <= '0;
      r_len_out <= '0;
      r_seq_err <= 1'b0;
      r_len_err <= 1'b0;
      r_ovf_err <= 1'b0;
      r_hdr_err <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      r_idle    <= '0;
      r_to_err  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_hold    <= w_hold_nxt;
      r_full    <= w_full_nxt;
      r_count   <= w_count_nxt;
      r_ovf     <= w_ovf_nxt;
      r_exp_seq <= w_exp_seq_nxt;
      r_dout    <= w_dout_nxt;
      r_vout    <= w_vout_nxt;
      r_lout    <= w_lout_nxt;
      r_done    <= w_done_nxt;
      r_seq_out <= w_seq_out_nxt;
      r_len_out <= w_len_out_nxt;
      r_seq_err <= w_seq_err_nxt;
      r_len_err <= w_len_err_nxt;
      r_ovf_err <= w_ovf_err_nxt;
      r_hdr_err <= w_hdr_err_nxt;
`ifdef FRAME_TIMEOUT_EN
      r_idle    <= w_idle_nxt;
      r_to_err  <= w_to_err_nxt;
`endif
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold;
    w_full_nxt    = r_full;
    w_count_nxt   = r_count;
    w_ovf_nxt     = r_ovf;
    w_exp_seq_nxt = r_exp_seq;
    w_dout_nxt    = r_dout;
    w_vout_nxt    = 1'b0;
    w_lout_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_seq_out_nxt = r_seq_out;
    w_len_out_nxt = r_len_out;
    w_seq_err_nxt = 1'b0;
    w_len_err_nxt = 1'b0;
    w_ovf_err_nxt = 1'b0;
    w_hdr_err_nxt = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    w_idle_nxt    = r_idle;
    w_to_err_nxt  = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
`ifdef FRAME_TIMEOUT_EN
        w_idle_nxt = '0;
`endif
        if (validIn) begin
          if ((dataIn == HEADER_WORD) && !lastIn) begin
            w_state_nxt = ST_PAYLOAD;
            w_count_nxt = '0;
            w_full_nxt  = 1'b0;
            w_ovf_nxt   = 1'b0;
          end else begin
            w_hdr_err_nxt = 1'b1;
          end
        end
      end

      ST_PAYLOAD: begin
        if (validIn) begin
`ifdef FRAME_TIMEOUT_EN
          w_idle_nxt = '0;
`endif
          if (!lastIn) begin
            // Words past MAX_LEN are dropped and only flagged at the footer
            if (r_count < CNT_W'(MAX_LEN)) begin
              if (r_full) begin
                w_dout_nxt = r_hold;
                w_vout_nxt = 1'b1;
              end
              w_hold_nxt  = dataIn;
              w_full_nxt  = 1'b1;
              w_count_nxt = r_count + CNT_W'(1);
            end else begin
              w_ovf_nxt = 1'b1;
            end
          end else begin
            w_dout_nxt    = r_hold;
            w_vout_nxt    = r_full;
            w_lout_nxt    = r_full;
            w_done_nxt    = 1'b1;
            w_seq_out_nxt = dataIn[31:16];
            w_len_out_nxt = r_count;
            w_seq_err_nxt = (dataIn[31:16] != r_exp_seq);
            w_len_err_nxt = (dataIn[15:0] != r_count);
            w_ovf_err_nxt = r_ovf;
            w_exp_seq_nxt = dataIn[31:16] + 16'd1;
            w_ovf_nxt     = 1'b0;
            w_full_nxt    = 1'b0;
            w_count_nxt   = '0;
            w_state_nxt   = ST_IDLE;
          end
        end
`ifdef FRAME_TIMEOUT_EN
        else if (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          // Abort: flush the held word as the last one, leave expected seq alone
          w_dout_nxt    = r_hold;
          w_vout_nxt    = r_full;
          w_lout_nxt    = r_full;
          w_done_nxt    = 1'b1;
          w_to_err_nxt  = 1'b1;
          w_len_out_nxt = r_count;
          w_ovf_nxt     = 1'b0;
          w_full_nxt    = 1'b0;
          w_count_nxt   = '0;
          w_idle_nxt    = '0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_idle_nxt = r_idle + IDLE_W'(1);
        end
`endif
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign dataOut  = r_dout;
  assign validOut = r_vout;
  assign lastOut  = r_lout;
  assign pktDone  = r_done;
  assign seqOut   = r_seq_out;
  assign lenOut   = r_len_out;
  assign seqErr   = r_seq_err;
  assign lenErr   = r_len_err;
  assign ovfErr   = r_ovf_err;
  assign hdrErr   = r_hdr_err;
`ifdef FRAME_TIMEOUT_EN
  assign toErr    = r_to_err;
`else
  assign toErr    = 1'b0;
`endif

endmodule
